// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one external multiplier between
// N_REQ requesters. A grant latches the winner's operands, holds them on
// mul_a/mul_b while waiting for mul_rdy, then returns the product with a
// one-cycle ack to the winner.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   req      - per-requester level request, held until its ack
//   a, b     - packed operands, requester i at bits [32i+31:32i]
//   ack      - one-cycle completion pulse, one-hot or zero
//   y        - product for the acked requester (holds between acks)
//   busy     - high whenever the FSM is not IDLE
//   gnt_id   - index of the requester owning the multiplier
//   mul_req  - request to the multiplier, high exactly while BUSY
//   mul_a/b  - registered operands to the multiplier
//   mul_y    - multiplier product
//   mul_rdy  - multiplier result valid (ignored outside BUSY)
module mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2   // must equal $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  a,
  input  logic [32*N_REQ-1:0]  b,
  output logic [N_REQ-1:0]     ack,
  output logic [63:0]          y,
  output logic                 busy,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 mul_req,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_y,
  input  logic                 mul_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [63:0]     y_q, y_d;

  // Round-robin pick. The first pass takes the lowest requester above ptr;
  // if none, the second pass wraps and takes the lowest requester overall
  // (which is then necessarily at or below ptr).
  logic            found;
  logic [ID_W-1:0] pick_id;
  logic [31:0]     pick_a, pick_b;

  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    pick_a  = '0;
    pick_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > ptr_q)) begin
        found   = 1'b1;
        pick_id = ID_W'(i);
        pick_a  = a[i*32 +: 32];
        pick_b  = b[i*32 +: 32];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        pick_id = ID_W'(i);
        pick_a  = a[i*32 +: 32];
        pick_b  = b[i*32 +: 32];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick_id;
          op_a_d  = pick_a;
          op_b_d  = pick_b;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Operands stay frozen; wait as long as the multiplier needs.
        if (mul_rdy) begin
          y_d     = mul_y;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Pointer moves only on completion, so an aborted (reset)
        // operation never shifts priority.
        ptr_d   = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);  // requester 0 wins first after reset
      gnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      y_q     <= y_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign busy    = (state_q != S_IDLE);
  assign mul_req = (state_q == S_BUSY);
  assign mul_a   = op_a_q;
  assign mul_b   = op_b_q;
  assign gnt_id  = gnt_q;
  assign y       = y_q;
  assign ack     = (state_q == S_RESP) ? (N_REQ'(1) << gnt_q) : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table of single-operation vectors
// plus hand-written sequences for contention, slow multiplier, reset while
// busy, spurious mul_rdy and req dropping before ack.
module tb_mult_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] a, b;
  logic [3:0]   ack;
  logic [63:0]  y;
  logic         busy;
  logic [1:0]   gnt_id;
  logic         mul_req;
  logic [31:0]  mul_a, mul_b;
  logic [63:0]  mul_y;
  logic         mul_rdy;

  // Multiplier model: fast mode answers in the request cycle, slow mode on
  // the fifth BUSY cycle; spur forces mul_rdy regardless of state.
  logic         fast;
  logic         spur;
  logic [3:0]   wait_cnt = '0;
  int           cyc = 0;

  assign mul_y   = {32'd0, mul_a} * {32'd0, mul_b};
  assign mul_rdy = spur | (mul_req & (fast | (wait_cnt == 4'd4)));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mul_req) wait_cnt <= '0;
    else          wait_cnt <= wait_cnt + 4'd1;
  end

  mult_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a       (a),
    .b       (b),
    .ack     (ack),
    .y       (y),
    .busy    (busy),
    .gnt_id  (gnt_id),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_y   (mul_y),
    .mul_rdy (mul_rdy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  gnt;
    logic [63:0] y;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] op_a[4];
  logic [31:0] op_b[4];
  logic [63:0] prod[4];
  int          ack_cyc[4];
  logic [31:0] hold_a, hold_b;
  logic [63:0] y_hold;
  int          n_busy;

  initial begin
    op_a[0] = 32'd3;         op_b[0] = 32'd5;    prod[0] = 64'd15;
    op_a[1] = 32'd7;         op_b[1] = 32'd9;    prod[1] = 64'd63;
    op_a[2] = 32'd100;       op_b[2] = 32'd1000; prod[2] = 64'h186A0;
    op_a[3] = 32'hFFFFFFFF;  op_b[3] = 32'd2;    prod[3] = 64'h1_FFFF_FFFE;

    // Sequence from reset (ptr=3); each entry is one complete operation.
    vecs[0] = '{4'b0001, 2'd0, prod[0]};
    vecs[1] = '{4'b0001, 2'd0, prod[0]};
    vecs[2] = '{4'b0011, 2'd1, prod[1]};  // ptr 0 -> search starts at 1
    vecs[3] = '{4'b0011, 2'd0, prod[0]};  // ptr 1 -> 2,3 empty, wrap to 0
    vecs[4] = '{4'b1100, 2'd2, prod[2]};
    vecs[5] = '{4'b1101, 2'd3, prod[3]};  // ptr 2 -> 3 before 0
    vecs[6] = '{4'b1001, 2'd0, prod[0]};  // ptr 3 -> wrap to 0
    vecs[7] = '{4'b1001, 2'd3, prod[3]};  // ptr 0 -> 3
    vecs[8] = '{4'b0110, 2'd1, prod[1]};
    vecs[9] = '{4'b0101, 2'd2, prod[2]};  // ptr 1 -> 2

    a    = {op_a[3], op_a[2], op_a[1], op_a[0]};
    b    = {op_b[3], op_b[2], op_b[1], op_b[0]};
    rst  = 1'b1;
    req  = '0;
    fast = 1'b1;
    spur = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_req", mul_req, 0);
    check("rst_y", y, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    rst = 1'b0;

    // Table-driven single operations with a single-cycle multiplier.
    for (int v = 0; v < 10; v++) begin
      req = vecs[v].req;
      tick();
      check($sformatf("v%0d_busy1", v), busy, 1);
      check($sformatf("v%0d_mul_req", v), mul_req, 1);
      check($sformatf("v%0d_gnt", v), gnt_id, vecs[v].gnt);
      check($sformatf("v%0d_mul_a", v), mul_a, op_a[vecs[v].gnt]);
      check($sformatf("v%0d_mul_b", v), mul_b, op_b[vecs[v].gnt]);
      check($sformatf("v%0d_ack1", v), ack, 0);
      tick();
      check($sformatf("v%0d_ack", v), ack, 4'b0001 << vecs[v].gnt);
      check($sformatf("v%0d_y", v), y, vecs[v].y);
      check($sformatf("v%0d_busy2", v), busy, 1);
      check($sformatf("v%0d_mul_req2", v), mul_req, 0);
      req = '0;
      tick();
      check($sformatf("v%0d_idle_ack", v), ack, 0);
      check($sformatf("v%0d_idle_busy", v), busy, 0);
      check($sformatf("v%0d_y_hold", v), y, vecs[v].y);
    end

    // Contention from reset: all four requesting, each dropped after ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("cont%0d_gnt", k), gnt_id, k);
      check($sformatf("cont%0d_ack_early", k), ack, 0);
      tick();
      check($sformatf("cont%0d_ack", k), ack, 4'b0001 << k);
      check($sformatf("cont%0d_y", k), y, prod[k]);
      ack_cyc[k] = cyc;
      if (k > 0) check($sformatf("cont%0d_spacing", k), ack_cyc[k] - ack_cyc[k-1], 3);
      req[k] = 1'b0;
      tick();
    end
    check("cont_done_busy", busy, 0);

    // Slow multiplier with maximum operands (ptr is now 3, so 0 wins).
    a[31:0] = 32'hFFFFFFFF;
    b[31:0] = 32'hFFFFFFFF;
    fast    = 1'b0;
    req     = 4'b0001;
    tick();
    n_busy = 0;
    hold_a = mul_a;
    hold_b = mul_b;
    for (int i = 0; i < 10; i++) begin
      if (!mul_req) break;
      n_busy++;
      check("slow_ack_wait", ack, 0);
      check("slow_mul_a", mul_a, 32'hFFFFFFFF);
      check("slow_mul_b_stable", mul_b, hold_b);
      tick();
    end
    check("slow_busy_cycles", n_busy, 5);
    check("slow_ack", ack, 4'b0001);
    check("slow_y", y, 64'hFFFFFFFE00000001);
    req = '0;
    tick();

    // Reset while BUSY: operation discarded, ptr back to 3.
    req = 4'b0010;
    tick();
    check("rb_mul_req", mul_req, 1);
    check("rb_gnt", gnt_id, 1);
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check("rb_busy", busy, 0);
    check("rb_mul_req_low", mul_req, 0);
    check("rb_gnt_clr", gnt_id, 0);
    check("rb_mul_a_clr", mul_a, 0);
    check("rb_y_clr", y, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rb_no_ack%0d", i), ack, 0);
      tick();
    end
    fast = 1'b1;
    req  = 4'b0101;  // stale ptr 0 would pick 2; reset ptr 3 picks 0
    tick();
    check("rb_ptr_gnt0", gnt_id, 0);
    tick();
    check("rb_ptr_ack0", ack, 4'b0001);
    req = '0;
    tick();
    req = 4'b0100;
    tick();
    check("rb_gnt2", gnt_id, 2);
    tick();
    check("rb_ack2", ack, 4'b0100);
    check("rb_y2", y, prod[2]);
    req = '0;
    tick();

    // Spurious mul_rdy while IDLE.
    y_hold = y;
    spur   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("spur_busy%0d", i), busy, 0);
      check($sformatf("spur_ack%0d", i), ack, 0);
      check($sformatf("spur_y%0d", i), y, y_hold);
    end
    spur = 1'b0;

    // req dropped right after grant still completes.
    req = 4'b1000;
    tick();
    check("drop_gnt", gnt_id, 3);
    req = '0;
    tick();
    check("drop_ack", ack, 4'b1000);
    check("drop_y", y, prod[3]);
    tick();
    check("drop_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
